// File: rtl/probe_sched.sv
// rtl/probe_sched.sv - round-robin scheduler of internal probes onto the MSHR allocation port
// with per-set in-flight tracking so a set never has two internal probes outstanding.
module probe_sched #(
    parameter int SET_BITS = 10,
    parameter int TAG_BITS = 20,
    parameter int SRC_BITS = 6,
    parameter int TRACK    = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ph_valid,
    output logic                       ph_ready,
    input  logic [SRC_BITS-1:0]        ph_source,
    input  logic [SET_BITS-1:0]        ph_set,
    input  logic [TAG_BITS-1:0]        ph_tag,
    input  logic                       cmo_valid,
    output logic                       cmo_ready,
    input  logic [SRC_BITS-1:0]        cmo_source,
    input  logic [SET_BITS-1:0]        cmo_set,
    input  logic [TAG_BITS-1:0]        cmo_tag,
    input  logic                       cmo_need_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SRC_BITS-1:0]        out_source,
    output logic [SET_BITS-1:0]        out_set,
    output logic [TAG_BITS-1:0]        out_tag,
    output logic                       out_from_probe_helper,
    output logic                       out_from_cmo_helper,
    output logic                       out_need_probe_ack_data,
    input  logic                       rel_valid,
    input  logic [SET_BITS-1:0]        rel_set,
    output logic [$clog2(TRACK+1)-1:0] inflight,
    output logic                       full
);

    localparam int CNT_W = $clog2(TRACK + 1);
    localparam int IDX_W = $clog2(TRACK);

    logic [TRACK-1:0]    trk_valid;
    logic [SET_BITS-1:0] trk_set [TRACK];
    logic                rr_cmo;

    logic             ph_hit;
    logic             cmo_hit;
    logic             can_load;
    logic             elig_ph;
    logic             elig_cmo;
    logic             grant_ph;
    logic             grant_cmo;
    logic             grant;
    logic [IDX_W-1:0] free_idx;
    logic [CNT_W-1:0] count;

    always_comb begin
        ph_hit  = 1'b0;
        cmo_hit = 1'b0;
        count   = '0;
        for (int i = 0; i < TRACK; i++) begin
            if (trk_valid[i] && trk_set[i] == ph_set)  ph_hit  = 1'b1;
            if (trk_valid[i] && trk_set[i] == cmo_set) cmo_hit = 1'b1;
            count = count + CNT_W'(trk_valid[i]);
        end
    end

    // Scan downward so the lowest-index free entry is the one left standing.
    always_comb begin
        free_idx = '0;
        for (int i = TRACK - 1; i >= 0; i--) begin
            if (!trk_valid[i]) free_idx = IDX_W'(i);
        end
    end

    assign full      = &trk_valid;
    assign inflight  = count;
    assign can_load  = !out_valid || out_ready;
    assign elig_ph   = ph_valid  && !ph_hit  && !full && can_load;
    assign elig_cmo  = cmo_valid && !cmo_hit && !full && can_load;
    assign grant_ph  = elig_ph && (!elig_cmo || !rr_cmo);
    assign grant_cmo = elig_cmo && !grant_ph;
    assign grant     = grant_ph || grant_cmo;
    assign ph_ready  = grant_ph;
    assign cmo_ready = grant_cmo;

    // A release only clears valid entries and allocation only targets a free one,
    // so a same-cycle clear and allocate never collide on an entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trk_valid <= '0;
            for (int i = 0; i < TRACK; i++) trk_set[i] <= '0;
        end else begin
            for (int i = 0; i < TRACK; i++) begin
                if (rel_valid && trk_valid[i] && trk_set[i] == rel_set) trk_valid[i] <= 1'b0;
                if (grant && free_idx == IDX_W'(i)) begin
                    trk_valid[i] <= 1'b1;
                    trk_set[i]   <= grant_ph ? ph_set : cmo_set;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_cmo                  <= 1'b0;
            out_valid               <= 1'b0;
            out_source              <= '0;
            out_set                 <= '0;
            out_tag                 <= '0;
            out_from_probe_helper   <= 1'b0;
            out_from_cmo_helper     <= 1'b0;
            out_need_probe_ack_data <= 1'b0;
        end else if (grant) begin
            rr_cmo                  <= grant_ph;
            out_valid               <= 1'b1;
            out_source              <= grant_ph ? ph_source : cmo_source;
            out_set                 <= grant_ph ? ph_set : cmo_set;
            out_tag                 <= grant_ph ? ph_tag : cmo_tag;
            out_from_probe_helper   <= grant_ph;
            out_from_cmo_helper     <= grant_cmo;
            out_need_probe_ack_data <= grant_ph ? 1'b1 : cmo_need_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_probe_sched.sv
// tb/tb_probe_sched.sv - directed self-checking bench for probe_sched.
module tb_probe_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ph_valid = 1'b0;
    logic        ph_ready;
    logic [5:0]  ph_source = '0;
    logic [9:0]  ph_set = '0;
    logic [19:0] ph_tag = '0;
    logic        cmo_valid = 1'b0;
    logic        cmo_ready;
    logic [5:0]  cmo_source = '0;
    logic [9:0]  cmo_set = '0;
    logic [19:0] cmo_tag = '0;
    logic        cmo_need_data = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_source;
    logic [9:0]  out_set;
    logic [19:0] out_tag;
    logic        out_from_probe_helper;
    logic        out_from_cmo_helper;
    logic        out_need_probe_ack_data;
    logic        rel_valid = 1'b0;
    logic [9:0]  rel_set = '0;
    logic [2:0]  inflight;
    logic        full;

    int tests = 0;
    int fails = 0;

    probe_sched #(.SET_BITS(10), .TAG_BITS(20), .SRC_BITS(6), .TRACK(4)) dut (
        .clock(clock), .reset(reset),
        .ph_valid(ph_valid), .ph_ready(ph_ready), .ph_source(ph_source),
        .ph_set(ph_set), .ph_tag(ph_tag),
        .cmo_valid(cmo_valid), .cmo_ready(cmo_ready), .cmo_source(cmo_source),
        .cmo_set(cmo_set), .cmo_tag(cmo_tag), .cmo_need_data(cmo_need_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_source(out_source),
        .out_set(out_set), .out_tag(out_tag),
        .out_from_probe_helper(out_from_probe_helper),
        .out_from_cmo_helper(out_from_cmo_helper),
        .out_need_probe_ack_data(out_need_probe_ack_data),
        .rel_valid(rel_valid), .rel_set(rel_set),
        .inflight(inflight), .full(full)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        ph_valid = 0; cmo_valid = 0; rel_valid = 0; out_ready = 0; cmo_need_data = 0;
        reset = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1;
    endtask

    task automatic test_reset();
        reset = 0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        tests++; if (inflight !== 3'd0) begin fails++; $display("FAIL reset_inflight got %0d want 0", inflight); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %0b want 0", full); end
        tests++; if (out_set !== 10'h0 || out_tag !== 20'h0 || out_source !== 6'h0)
            begin fails++; $display("FAIL reset_payload got set=%h tag=%h src=%h want 0", out_set, out_tag, out_source); end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        out_ready = 1; ph_valid = 1; ph_set = 10'h12; ph_tag = 20'h5; ph_source = 6'd3;
        #1;
        tests++; if (ph_ready !== 1'b1 || cmo_ready !== 1'b0)
            begin fails++; $display("FAIL single_ready got ph=%0b cmo=%0b want 1 0", ph_ready, cmo_ready); end
        step();
        ph_valid = 0;
        tests++; if (out_valid !== 1'b1 || out_set !== 10'h12 || out_tag !== 20'h5 || out_source !== 6'd3)
            begin fails++; $display("FAIL single_out got v=%0b set=%h tag=%h src=%0d want 1 012 5 3", out_valid, out_set, out_tag, out_source); end
        tests++; if (out_from_probe_helper !== 1'b1 || out_from_cmo_helper !== 1'b0 || out_need_probe_ack_data !== 1'b1)
            begin fails++; $display("FAIL single_flags got ph=%0b cmo=%0b nd=%0b want 1 0 1", out_from_probe_helper, out_from_cmo_helper, out_need_probe_ack_data); end
        tests++; if (inflight !== 3'd1) begin fails++; $display("FAIL single_inflight got %0d want 1", inflight); end
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain got %0b want 0", out_valid); end
        rel_valid = 1; rel_set = 10'h12;
        step();
        rel_valid = 0;
        tests++; if (inflight !== 3'd0) begin fails++; $display("FAIL single_release got %0d want 0", inflight); end
    endtask

    task automatic test_alternate();
        logic [9:0] prev;
        logic [9:0] exp_set;
        apply_reset();
        out_ready = 1; ph_valid = 1; cmo_valid = 1;
        prev = '0;
        for (int i = 0; i < 6; i++) begin
            ph_set = 10'h100 + 10'(i); cmo_set = 10'h200 + 10'(i);
            cmo_need_data = i[1];
            rel_valid = (i > 0); rel_set = prev;
            exp_set = (i % 2 == 0) ? ph_set : cmo_set;
            #1;
            tests++; if (ph_ready !== (i % 2 == 0) || cmo_ready !== (i % 2 == 1))
                begin fails++; $display("FAIL alt_grant[%0d] got ph=%0b cmo=%0b", i, ph_ready, cmo_ready); end
            step();
            tests++; if (out_valid !== 1'b1 || out_set !== exp_set || out_from_cmo_helper !== (i % 2 == 1))
                begin fails++; $display("FAIL alt_out[%0d] got v=%0b set=%h cmo=%0b want set=%h", i, out_valid, out_set, out_from_cmo_helper, exp_set); end
            if (i % 2 == 1) begin
                tests++; if (out_need_probe_ack_data !== i[1])
                    begin fails++; $display("FAIL alt_need[%0d] got %0b want %0b", i, out_need_probe_ack_data, i[1]); end
            end
            tests++; if (inflight !== 3'd1) begin fails++; $display("FAIL alt_inflight[%0d] got %0d want 1", i, inflight); end
            prev = exp_set;
        end
        ph_valid = 0; cmo_valid = 0; rel_valid = 0;
    endtask

    task automatic test_block();
        apply_reset();
        out_ready = 1; ph_valid = 1; ph_set = 10'h40;
        step();
        ph_valid = 0;
        cmo_valid = 1; cmo_set = 10'h40; cmo_tag = 20'h77; cmo_need_data = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (cmo_ready !== 1'b0) begin fails++; $display("FAIL block_wait[%0d] got %0b want 0", i, cmo_ready); end
            step();
        end
        rel_valid = 1; rel_set = 10'h40;
        #1;
        tests++; if (cmo_ready !== 1'b0) begin fails++; $display("FAIL block_same_cycle got %0b want 0", cmo_ready); end
        step();
        rel_valid = 0;
        #1;
        tests++; if (cmo_ready !== 1'b1 || inflight !== 3'd0)
            begin fails++; $display("FAIL block_freed got rdy=%0b infl=%0d want 1 0", cmo_ready, inflight); end
        step();
        cmo_valid = 0;
        tests++; if (out_valid !== 1'b1 || out_set !== 10'h40 || out_from_cmo_helper !== 1'b1 || out_need_probe_ack_data !== 1'b0)
            begin fails++; $display("FAIL block_out got v=%0b set=%h cmo=%0b nd=%0b want 1 040 1 0", out_valid, out_set, out_from_cmo_helper, out_need_probe_ack_data); end
        tests++; if (inflight !== 3'd1) begin fails++; $display("FAIL block_inflight got %0d want 1", inflight); end
    endtask

    task automatic test_full();
        apply_reset();
        out_ready = 1; ph_valid = 1;
        for (int i = 0; i < 4; i++) begin
            ph_set = 10'h10 + 10'(i);
            step();
        end
        ph_valid = 1; ph_set = 10'h20;
        cmo_valid = 1; cmo_set = 10'h21;
        #1;
        tests++; if (full !== 1'b1 || inflight !== 3'd4)
            begin fails++; $display("FAIL full_state got full=%0b infl=%0d want 1 4", full, inflight); end
        tests++; if (ph_ready !== 1'b0 || cmo_ready !== 1'b0)
            begin fails++; $display("FAIL full_ready got ph=%0b cmo=%0b want 0 0", ph_ready, cmo_ready); end
        rel_valid = 1; rel_set = 10'h11;
        #1;
        tests++; if (ph_ready !== 1'b0 || cmo_ready !== 1'b0)
            begin fails++; $display("FAIL full_rel_cycle got ph=%0b cmo=%0b want 0 0", ph_ready, cmo_ready); end
        step();
        rel_valid = 0;
        #1;
        tests++; if (ph_ready !== 1'b0 || cmo_ready !== 1'b1 || full !== 1'b0)
            begin fails++; $display("FAIL full_one_slot got ph=%0b cmo=%0b full=%0b want 0 1 0", ph_ready, cmo_ready, full); end
        step();
        #1;
        tests++; if (full !== 1'b1 || ph_ready !== 1'b0 || cmo_ready !== 1'b0 || out_set !== 10'h21)
            begin fails++; $display("FAIL full_refill got full=%0b ph=%0b cmo=%0b set=%h want 1 0 0 021", full, ph_ready, cmo_ready, out_set); end
        ph_valid = 0; cmo_valid = 0;
    endtask

    task automatic test_stall();
        apply_reset();
        out_ready = 0; ph_valid = 1; ph_set = 10'h55; ph_tag = 20'hABCDE; ph_source = 6'd9;
        step();
        ph_set = 10'h56; ph_tag = 20'h12345; ph_source = 6'd10;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if (out_valid !== 1'b1 || out_set !== 10'h55 || out_tag !== 20'hABCDE || ph_ready !== 1'b0)
                begin fails++; $display("FAIL stall_hold[%0d] got v=%0b set=%h tag=%h rdy=%0b", i, out_valid, out_set, out_tag, ph_ready); end
            step();
        end
        out_ready = 1;
        #1;
        tests++; if (ph_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready got %0b want 1", ph_ready); end
        step();
        ph_valid = 0;
        tests++; if (out_valid !== 1'b1 || out_set !== 10'h56 || out_tag !== 20'h12345 || out_source !== 6'd10)
            begin fails++; $display("FAIL stall_next got v=%0b set=%h tag=%h src=%0d want 1 056 12345 10", out_valid, out_set, out_tag, out_source); end
        tests++; if (inflight !== 3'd2) begin fails++; $display("FAIL stall_inflight got %0d want 2", inflight); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        out_ready = 1; ph_valid = 1;
        for (int i = 0; i < 3; i++) begin
            ph_set = 10'h30 + 10'(i);
            step();
        end
        ph_valid = 0; out_ready = 0;
        tests++; if (out_valid !== 1'b1 || inflight !== 3'd3)
            begin fails++; $display("FAIL arst_pre got v=%0b infl=%0d want 1 3", out_valid, inflight); end
        #2 reset = 0;
        #1;
        tests++; if (out_valid !== 1'b0 || inflight !== 3'd0 || full !== 1'b0 || out_set !== 10'h0)
            begin fails++; $display("FAIL arst_now got v=%0b infl=%0d full=%0b set=%h want 0 0 0 000", out_valid, inflight, full, out_set); end
        #2 reset = 1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_block();
        test_full();
        test_stall();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
